// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM model behind the memory_control RAM port.
// Every request is held off for LAT BUSY cycles and then completed in a
// single ACCESS cycle. Illegal requests are parked in ERROR. Reset clears
// the FSM and every memory word.
module ram_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  // Handshake: the requester raises exactly one of ramREN/ramWEN with a
  // stable ramaddr and holds it until it observes ramstate == ACCESS. The
  // access completes in that cycle: read data is on ramload during ACCESS,
  // and write data on ramstore is captured at the edge that ends ACCESS.
  // ACCESS always returns to FREE, so a request that is still held afterwards
  // is treated as a brand-new request.

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [3:0] CNT_RELOAD = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic [ADDR_W-1:0]       widx;
  logic [ADDR_W-1:0]       widx_nxt;
  logic                    wop;       // 1 = write, 0 = read
  logic                    wop_nxt;
  logic [DEPTH-1:0][31:0]  mem;

  logic              any_req;
  logic              req;
  logic              illegal;
  logic [31:0]       hi_bits;
  logic [ADDR_W-1:0] idx;
  logic              changed;

  // Request decode: address legality and word index.
  assign any_req = ramREN | ramWEN;
  assign req     = ramREN ^ ramWEN;
  assign hi_bits = ramaddr >> (ADDR_W + 2);
  assign idx     = ramaddr[ADDR_W+1:2];
  assign illegal = any_req &&
                   ((ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) || (hi_bits != 32'd0));
  assign changed = (idx != widx) || (ramWEN != wop);

  assign ramstate = state;

  // Next-state logic for the access FSM and its latched request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    widx_nxt  = widx;
    wop_nxt   = wop;
    case (state)
      FREE: begin
        if (illegal) begin
          state_nxt = ERROR;
        end else if (req) begin
          widx_nxt = idx;
          wop_nxt  = ramWEN;
          if (LAT == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_RELOAD;
          end
        end
      end
      BUSY: begin
        if (!any_req) begin
          // Requester gave up; the access is abandoned.
          state_nxt = FREE;
        end else if (illegal) begin
          state_nxt = ERROR;
        end else if (changed) begin
          // New target mid-wait: restart the full wait for the new request.
          widx_nxt = idx;
          wop_nxt  = ramWEN;
          cnt_nxt  = CNT_RELOAD;
        end else if (cnt == 4'd0) begin
          state_nxt = ACCESS;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS: begin
        state_nxt = FREE;
      end
      ERROR: begin
        if (!illegal) begin
          state_nxt = FREE;
        end
      end
      default: begin
        state_nxt = FREE;
      end
    endcase
  end

  // FSM and latched-request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FREE;
      cnt   <= 4'd0;
      widx  <= '0;
      wop   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      widx  <= widx_nxt;
      wop   <= wop_nxt;
    end
  end

  // Storage: cleared on reset, written only at the end of a write ACCESS.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem <= '0;
    end else if ((state == ACCESS) && wop) begin
      mem[widx] <= ramstore;
    end
  end

  // Read data is driven only during a read ACCESS, zero otherwise.
  always_comb begin
    ramload = 32'd0;
    if ((state == ACCESS) && !wop) begin
      ramload = mem[widx];
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances (LAT=2, LAT=0, LAT=4)
// share clock, reset, address and store data; each has its own request
// strobes and outputs.
module tb_ram_responder;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ren_a, wen_a, ren_0, wen_0, ren_4, wen_4;
  logic [31:0] addr, store;
  logic [31:0] load_a, load_0, load_4;
  logic [1:0]  st_a, st_0, st_4;

  int n_checks = 0;
  int n_pass   = 0;

  // Clock and global watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ram_responder #(.ADDR_W(8), .LAT(2)) u_dut (
    .CLK(CLK), .RST(RST), .ramREN(ren_a), .ramWEN(wen_a),
    .ramaddr(addr), .ramstore(store), .ramload(load_a), .ramstate(st_a)
  );

  ram_responder #(.ADDR_W(8), .LAT(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .ramREN(ren_0), .ramWEN(wen_0),
    .ramaddr(addr), .ramstore(store), .ramload(load_0), .ramstate(st_0)
  );

  ram_responder #(.ADDR_W(8), .LAT(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .ramREN(ren_4), .ramWEN(wen_4),
    .ramaddr(addr), .ramstore(store), .ramload(load_4), .ramstate(st_4)
  );

  function automatic logic [1:0] st_of(input int sel);
    case (sel)
      0:       return st_a;
      1:       return st_0;
      default: return st_4;
    endcase
  endfunction

  function automatic logic [31:0] load_of(input int sel);
    case (sel)
      0:       return load_a;
      1:       return load_0;
      default: return load_4;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int sel, input logic r, input logic w);
    case (sel)
      0:       begin ren_a = r; wen_a = w; end
      1:       begin ren_0 = r; wen_0 = w; end
      default: begin ren_4 = r; wen_4 = w; end
    endcase
  endtask

  // Driver: full write handshake on one instance, bounded wait for ACCESS.
  task automatic do_write(input int sel, input logic [31:0] a, input logic [31:0] d);
    bit found = 0;
    addr  = a;
    store = d;
    set_req(sel, 1'b0, 1'b1);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (st_of(sel) == S_ACCESS) found = 1;
      else tick();
    end
    n_checks++;
    if (!found) $display("FAIL write_timeout: inst %0d addr %h never reached ACCESS", sel, a);
    else n_pass++;
    tick();
    set_req(sel, 1'b0, 1'b0);
    tick();
  endtask

  // Driver: full read handshake, returns the data seen during ACCESS.
  task automatic do_read(input int sel, input logic [31:0] a, output logic [31:0] d);
    bit found = 0;
    d    = 32'hxxxx_xxxx;
    addr = a;
    set_req(sel, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (st_of(sel) == S_ACCESS) begin
        found = 1;
        d = load_of(sel);
      end else begin
        tick();
      end
    end
    n_checks++;
    if (!found) $display("FAIL read_timeout: inst %0d addr %h never reached ACCESS", sel, a);
    else n_pass++;
    tick();
    set_req(sel, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    logic [1:0] exp_st [0:4];
    exp_st = '{S_FREE, S_BUSY, S_BUSY, S_ACCESS, S_FREE};
    RST = 1'b1;
    ren_a = 0; wen_a = 0; ren_0 = 0; wen_0 = 0; ren_4 = 0; wen_4 = 0;
    addr = 32'd0; store = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (st_a !== S_FREE) $display("FAIL reset_state_a: got %0d expected %0d", st_a, S_FREE);
    else n_pass++;
    n_checks++;
    if (load_a !== 32'd0) $display("FAIL reset_load_a: got %h expected 0", load_a);
    else n_pass++;
    n_checks++;
    if (st_0 !== S_FREE) $display("FAIL reset_state_0: got %0d expected %0d", st_0, S_FREE);
    else n_pass++;
    n_checks++;
    if (st_4 !== S_FREE) $display("FAIL reset_state_4: got %0d expected %0d", st_4, S_FREE);
    else n_pass++;
    tick();
    RST = 1'b0;
    // Read of word 0 after reset: ACCESS in cycle 3 with data 0.
    ren_a = 1'b1;
    addr  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ren_a = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_a !== exp_st[i]) $display("FAIL reset_read_seq cycle %0d: got %0d expected %0d", i, st_a, exp_st[i]);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (load_a !== 32'd0) $display("FAIL reset_read_data: got %h expected 0", load_a);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    logic [1:0] exp_st [0:4];
    exp_st = '{S_FREE, S_BUSY, S_BUSY, S_ACCESS, S_FREE};
    // Write 0x10: decoy store data until the ACCESS cycle.
    wen_a = 1'b1;
    addr  = 32'h10;
    for (int i = 0; i < 5; i++) begin
      store = (i == 3) ? 32'hDEADBEEF : 32'h0BADF00D;
      if (i == 4) wen_a = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_a !== exp_st[i]) $display("FAIL write_seq cycle %0d: got %0d expected %0d", i, st_a, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (load_a !== 32'd0) $display("FAIL write_load cycle %0d: got %h expected 0", i, load_a);
      else n_pass++;
      tick();
    end
    store = 32'h0;
    // Read back: data only in the ACCESS cycle.
    ren_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ren_a = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_a !== exp_st[i]) $display("FAIL read_seq cycle %0d: got %0d expected %0d", i, st_a, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (load_a !== ((i == 3) ? 32'hDEADBEEF : 32'd0))
        $display("FAIL read_data cycle %0d: got %h expected %h", i, load_a, (i == 3) ? 32'hDEADBEEF : 32'd0);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_st [0:8];
    logic [31:0] exp_ld [0:8];
    exp_st = '{S_FREE, S_BUSY, S_BUSY, S_ACCESS, S_FREE, S_BUSY, S_BUSY, S_ACCESS, S_FREE};
    exp_ld = '{32'd0, 32'd0, 32'd0, 32'h11111111, 32'd0, 32'd0, 32'd0, 32'h22222222, 32'd0};
    do_write(0, 32'h20, 32'h11111111);
    do_write(0, 32'h24, 32'h22222222);
    ren_a = 1'b1;
    addr  = 32'h20;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) addr = 32'h24;
      if (i == 8) ren_a = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_a !== exp_st[i]) $display("FAIL b2b_seq cycle %0d: got %0d expected %0d", i, st_a, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (load_a !== exp_ld[i]) $display("FAIL b2b_data cycle %0d: got %h expected %h", i, load_a, exp_ld[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_restart();
    logic [1:0]  exp_st [0:5];
    exp_st = '{S_FREE, S_BUSY, S_BUSY, S_BUSY, S_ACCESS, S_FREE};
    do_write(0, 32'h30, 32'hAAAA0030);
    do_write(0, 32'h34, 32'hBBBB0034);
    ren_a = 1'b1;
    addr  = 32'h30;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) addr = 32'h34;
      if (i == 5) ren_a = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_a !== exp_st[i]) $display("FAIL restart_seq cycle %0d: got %0d expected %0d", i, st_a, exp_st[i]);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (load_a !== 32'hBBBB0034) $display("FAIL restart_data: got %h expected BBBB0034", load_a);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [1:0]  exp_st [0:3];
    logic        c_ren  [0:2];
    logic [31:0] c_addr [0:2];
    logic [31:0] d;
    exp_st = '{S_FREE, S_ERROR, S_ERROR, S_FREE};
    c_ren  = '{1'b1, 1'b0, 1'b0};
    c_addr = '{32'h50, 32'h12, 32'h400};
    for (int c = 0; c < 3; c++) begin
      store = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
        if (i == 0) begin
          ren_a = c_ren[c];
          wen_a = 1'b1;
          addr  = c_addr[c];
        end
        if (i == 2) begin
          ren_a = 1'b0;
          wen_a = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if (st_a !== exp_st[i]) $display("FAIL error_seq case %0d cycle %0d: got %0d expected %0d", c, i, st_a, exp_st[i]);
        else n_pass++;
        tick();
      end
    end
    store = 32'h0;
    // None of the illegal writes may have touched memory.
    do_read(0, 32'h50, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL error_mem_50: got %h expected 0", d);
    else n_pass++;
    do_read(0, 32'h10, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) $display("FAIL error_mem_10: got %h expected DEADBEEF", d);
    else n_pass++;
    do_read(0, 32'h0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL error_mem_00: got %h expected 0", d);
    else n_pass++;
  endtask

  task automatic test_lat0();
    logic [1:0] exp_st [0:2];
    exp_st = '{S_FREE, S_ACCESS, S_FREE};
    wen_0 = 1'b1;
    addr  = 32'h8;
    store = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wen_0 = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_0 !== exp_st[i]) $display("FAIL lat0_write_seq cycle %0d: got %0d expected %0d", i, st_0, exp_st[i]);
      else n_pass++;
      tick();
    end
    store = 32'h0;
    ren_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ren_0 = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (st_0 !== exp_st[i]) $display("FAIL lat0_read_seq cycle %0d: got %0d expected %0d", i, st_0, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (load_0 !== ((i == 1) ? 32'hCAFEF00D : 32'd0))
        $display("FAIL lat0_read_data cycle %0d: got %h expected %h", i, load_0, (i == 1) ? 32'hCAFEF00D : 32'd0);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  exp_st [0:3];
    logic [31:0] d;
    exp_st = '{S_FREE, S_BUSY, S_BUSY, S_BUSY};
    wen_4 = 1'b1;
    addr  = 32'h40;
    store = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++;
      if (st_4 !== exp_st[i]) $display("FAIL rstmid_seq cycle %0d: got %0d expected %0d", i, st_4, exp_st[i]);
      else n_pass++;
      if (i < 3) tick();
    end
    // Third BUSY cycle: pull reset asynchronously.
    #1;
    RST   = 1'b1;
    wen_4 = 1'b0;
    #1;
    n_checks++;
    if (st_4 !== S_FREE) $display("FAIL rstmid_state: got %0d expected %0d", st_4, S_FREE);
    else n_pass++;
    tick();
    RST = 1'b0;
    tick();
    do_read(2, 32'h40, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rstmid_mem_40: got %h expected 0", d);
    else n_pass++;
    do_read(0, 32'h10, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL rstmid_mem_cleared: got %h expected 0", d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_restart();
    test_errors();
    test_lat0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
